// File: rtl/nand_async_cmd_seq_if.sv
// Byte-request handshake between the flash controller FSM (master) and
// the async command/address sequencer (slave).
interface nand_async_cmd_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_is_addr;
  logic [7:0] req_byte;
  logic       req_last;
  logic [2:0] req_ce;

  modport master (
    output req_valid, req_is_addr, req_byte, req_last, req_ce,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_is_addr, req_byte, req_last, req_ce,
    output req_ready
  );
endinterface

// File: rtl/nand_async_cmd_seq.sv
// Async-mode NAND command/address latch sequencer: paces CLE/ALE/WE#/CE#/DQ-OE
// for nand_phy. Define NAND_SEQ_STATS_EN to add byte/burst statistics counters.
module nand_async_cmd_seq #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_WP    = 3,
  parameter int unsigned T_WH    = 2,
  parameter int unsigned T_CH    = 2
) (
  input  logic                      v_clk0,
  input  logic                      v_rstn0,
  nand_async_cmd_seq_if.slave       req,
  output logic                      busy,
  output logic                      done,
  output logic                      ctrl_cle,
  output logic                      ctrl_ale,
  output logic                      ctrl_wrn,
  output logic                      ctrl_wen,
  output logic                      ctrl_wen_sel,
  output logic [7:0]                ctrl_cen,
  output logic                      dq_oe_n,
  output logic [7:0]                wr_data_rise,
  output logic [7:0]                wr_data_fall
`ifdef NAND_SEQ_STATS_EN
  ,
  output logic [15:0]               stat_bytes,
  output logic [15:0]               stat_bursts
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETUP     = 3'd1;
  localparam logic [2:0] WE_LOW    = 3'd2;
  localparam logic [2:0] WE_HIGH   = 3'd3;
  localparam logic [2:0] WAIT_NEXT = 3'd4;
  localparam logic [2:0] HOLD      = 3'd5;

  // Counter is loaded with duration-1 so a phase lasts exactly its cycle count.
  localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_WP    = 4'(T_WP - 1);
  localparam logic [3:0] LD_WH    = 4'(T_WH - 1);
  localparam logic [3:0] LD_CH    = 4'(T_CH - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       last_q;
  logic       ready_q;
  logic [7:0] data_q;
  logic       accept;

  assign accept        = req.req_valid & ready_q;
  assign req.req_ready = ready_q;
  assign ctrl_wrn      = 1'b1;
  assign ctrl_wen_sel  = 1'b1;
  assign wr_data_rise  = data_q;
  assign wr_data_fall  = data_q;

  always_ff @(posedge v_clk0 or negedge v_rstn0) begin
    if (!v_rstn0) begin
      state    <= IDLE;
      cnt      <= '0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ctrl_cle <= 1'b0;
      ctrl_ale <= 1'b0;
      ctrl_wen <= 1'b1;
      ctrl_cen <= '1;
      dq_oe_n  <= 1'b1;
      data_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, WAIT_NEXT: begin
          if (accept) begin
            // Chip select is taken only from the first byte of a burst.
            if (state == IDLE) ctrl_cen <= ~(8'd1 << req.req_ce);
            data_q   <= req.req_byte;
            last_q   <= req.req_last;
            ctrl_cle <= ~req.req_is_addr;
            ctrl_ale <= req.req_is_addr;
            dq_oe_n  <= 1'b0;
            ctrl_wen <= 1'b1;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
            cnt      <= LD_SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state    <= WE_LOW;
            cnt      <= LD_WP;
            ctrl_wen <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WE_LOW: begin
          if (cnt == '0) begin
            state    <= WE_HIGH;
            cnt      <= LD_WH;
            ctrl_wen <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WE_HIGH: begin
          if (cnt == '0) begin
            ctrl_cle <= 1'b0;
            ctrl_ale <= 1'b0;
            dq_oe_n  <= 1'b1;
            if (last_q) begin
              state <= HOLD;
              cnt   <= LD_CH;
            end else begin
              state   <= WAIT_NEXT;
              cnt     <= '0;
              ready_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state    <= IDLE;
            ctrl_cen <= '1;
            done     <= 1'b1;
            busy     <= 1'b0;
            ready_q  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          ready_q  <= 1'b1;
          busy     <= 1'b0;
          ctrl_cle <= 1'b0;
          ctrl_ale <= 1'b0;
          ctrl_wen <= 1'b1;
          ctrl_cen <= '1;
          dq_oe_n  <= 1'b1;
        end
      endcase
    end
  end

`ifdef NAND_SEQ_STATS_EN
  logic we_rise;
  logic burst_end;

  assign we_rise   = (state == WE_LOW) && (cnt == '0);
  assign burst_end = (state == HOLD) && (cnt == '0);

  always_ff @(posedge v_clk0 or negedge v_rstn0) begin
    if (!v_rstn0) begin
      stat_bytes  <= '0;
      stat_bursts <= '0;
    end else begin
      if (we_rise && stat_bytes != 16'hFFFF) stat_bytes <= stat_bytes + 16'd1;
      if (burst_end && stat_bursts != 16'hFFFF) stat_bursts <= stat_bursts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nand_async_cmd_seq.sv
// Self-checking bench for nand_async_cmd_seq: directed timing scenarios plus
// randomized bursts compared against a per-byte timeline model.
module tb_nand_async_cmd_seq;
  localparam int TS  = 2;
  localparam int TWP = 3;
  localparam int TWH = 2;
  localparam int TCH = 2;
  localparam int PER = TS + TWP + TWH;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nand_async_cmd_seq_if bus ();

  logic       busy, done, cle, ale, wrn, wen, wen_sel, oe_n;
  logic [7:0] cen, dr, df;
`ifdef NAND_SEQ_STATS_EN
  logic [15:0] sbytes, sbursts;
`endif

  nand_async_cmd_seq #(.T_SETUP(TS), .T_WP(TWP), .T_WH(TWH), .T_CH(TCH)) dut (
    .v_clk0       (clk),
    .v_rstn0      (rstn),
    .req          (bus),
    .busy         (busy),
    .done         (done),
    .ctrl_cle     (cle),
    .ctrl_ale     (ale),
    .ctrl_wrn     (wrn),
    .ctrl_wen     (wen),
    .ctrl_wen_sel (wen_sel),
    .ctrl_cen     (cen),
    .dq_oe_n      (oe_n),
    .wr_data_rise (dr),
    .wr_data_fall (df)
`ifdef NAND_SEQ_STATS_EN
    ,
    .stat_bytes   (sbytes),
    .stat_bursts  (sbursts)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  model_data = 8'h00;
  logic [30:0] obs;

  assign obs = {cen, cle, ale, wen, oe_n, dr, df, bus.req_ready, busy, done};

  function automatic logic [30:0] mk(input logic [7:0] c, input logic l, input logic a,
                                     input logic w, input logic o, input logic [7:0] d,
                                     input logic r, input logic b, input logic dn);
    return {c, l, a, w, o, d, d, r, b, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_is_addr = 1'b0;
    bus.req_byte    = 8'h00;
    bus.req_last    = 1'b0;
    bus.req_ce      = 3'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    model_data = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    checks++;
    if (obs !== mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs,
               mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
    end
    checks++;
    if ({wrn, wen_sel} !== 2'b11) begin
      errors++;
      $display("FAIL reset_consts got %b want 11", {wrn, wen_sel});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_release got %h", obs);
    end
    step();
  endtask

  task automatic test_single_cmd();
    logic [30:0] e;
    bus.req_valid = 1'b1; bus.req_byte = 8'hFF; bus.req_is_addr = 1'b0;
    bus.req_last  = 1'b1; bus.req_ce   = 3'd0;
    step();
    idle_inputs();
    for (int k = 1; k <= 12; k++) begin
      e = mk((k <= PER + TCH) ? 8'hFE : 8'hFF, k <= PER, 1'b0,
             !(k > TS && k <= TS + TWP), k > PER, 8'hFF,
             k > PER + TCH, k <= PER + TCH, k == PER + TCH + 1);
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_cmd cyc %0d got %h want %h", k, obs, e);
      end
      step();
    end
    model_data = 8'hFF;
  endtask

  task automatic test_burst();
    logic [7:0] bytes [6];
    int         fcyc  [8];
    logic [7:0] fdat  [8];
    logic [1:0] ftyp  [8];
    int nf = 0, idx = 0, dones = 0, cen_bad = 0;
    logic prev_wen = 1'b1;
    logic acc;
    bytes[0] = 8'h80;
    for (int i = 1; i < 6; i++) bytes[i] = 8'($urandom);
    bus.req_valid = 1'b1; bus.req_ce = 3'd3; bus.req_byte = bytes[0];
    bus.req_is_addr = 1'b0; bus.req_last = 1'b0;
    for (int k = 0; k < 120 && dones == 0; k++) begin
      @(negedge clk);
      if (prev_wen === 1'b1 && wen === 1'b0 && nf < 8) begin
        fcyc[nf] = k; fdat[nf] = dr; ftyp[nf] = {cle, ale}; nf++;
      end
      prev_wen = wen;
      if (done === 1'b1) dones++;
      else if (k > 0 && cen !== 8'hF7) cen_bad++;
      acc = bus.req_valid & bus.req_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 6) begin
          bus.req_byte = bytes[idx]; bus.req_is_addr = 1'b1;
          bus.req_last = (idx == 5); bus.req_ce = 3'($urandom);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    idle_inputs();
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL burst_done got %0d pulses want 1", dones);
    end
    checks++;
    if (nf !== 6) begin
      errors++;
      $display("FAIL burst_pulses got %0d want 6", nf);
    end
    for (int i = 0; i < nf && i < 6; i++) begin
      checks++;
      if (fcyc[i] !== TS + 1 + i * (PER + 1) || ftyp[i] !== ((i == 0) ? 2'b10 : 2'b01)
          || fdat[i] !== bytes[i]) begin
        errors++;
        $display("FAIL burst_pulse%0d got cyc %0d cle_ale %b data %h want cyc %0d cle_ale %b data %h",
                 i, fcyc[i], ftyp[i], fdat[i], TS + 1 + i * (PER + 1),
                 (i == 0) ? 2'b10 : 2'b01, bytes[i]);
      end
    end
    checks++;
    if (cen_bad !== 0) begin
      errors++;
      $display("FAIL burst_cen got %0d bad cycles want 0", cen_bad);
    end
    model_data = bytes[5];
  endtask

  task automatic test_stall();
    logic [2:0] c;
    logic [7:0] b1;
    int got = -1;
    c = 3'($urandom);
    b1 = 8'($urandom);
    bus.req_valid = 1'b1; bus.req_byte = 8'($urandom); bus.req_is_addr = 1'b0;
    bus.req_last = 1'b0; bus.req_ce = c;
    step();
    idle_inputs();
    for (int k = 1; k <= PER; k++) step();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({cen, wen, oe_n, busy, bus.req_ready} !== {~(8'd1 << c), 4'b1111}) begin
        errors++;
        $display("FAIL stall cyc %0d got %h want %h", k,
                 {cen, wen, oe_n, busy, bus.req_ready}, {~(8'd1 << c), 4'b1111});
      end
      step();
    end
    bus.req_valid = 1'b1; bus.req_byte = b1; bus.req_is_addr = 1'b1;
    bus.req_last = 1'b1; bus.req_ce = 3'($urandom);
    step();
    idle_inputs();
    for (int j = 1; j <= 20 && got < 0; j++) begin
      @(negedge clk);
      if (done === 1'b1) got = j;
      step();
    end
    checks++;
    if (got !== PER + TCH + 1) begin
      errors++;
      $display("FAIL stall_done got offset %0d want %0d", got, PER + TCH + 1);
    end
    model_data = b1;
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_byte = 8'($urandom); bus.req_is_addr = 1'b0;
    bus.req_last = 1'b1; bus.req_ce = 3'($urandom);
    step();
    idle_inputs();
    step();
    step();
    step();
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_prewen got %b want 0", wen);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (obs !== mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL rstmid_async got %h want %h", obs,
               mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
    end
    step();
    rstn = 1'b1;
    model_data = 8'h00;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL rstmid_after cyc %0d got %h", k, obs);
      end
      step();
    end
  endtask

  // Burst 0 forces ce 7 then 2 to show later-byte chip selects are ignored.
  task automatic test_random(input int bursts);
    for (int b = 0; b < bursts; b++) begin
      int n, len, rdy, w, o, v;
      logic [2:0]  ce0;
      logic [7:0]  act;
      logic [7:0]  byt [6];
      logic        isa [6];
      logic [2:0]  cei [6];
      int          pres[6];
      int          acc [6];
      logic [30:0] expv[256];
      n   = (b == 0) ? 2 : int'($urandom_range(1, 6));
      ce0 = (b == 0) ? 3'd7 : 3'($urandom);
      act = ~(8'd1 << ce0);
      rdy = 0;
      for (int i = 0; i < n; i++) begin
        byt[i] = 8'($urandom);
        isa[i] = 1'($urandom);
        cei[i] = (i == 0) ? ce0 : ((b == 0) ? 3'd2 : 3'($urandom));
        pres[i] = (i == 0) ? int'($urandom_range(0, 3))
                           : acc[i-1] + 1 + int'($urandom_range(0, 14));
        acc[i] = (pres[i] > rdy) ? pres[i] : rdy;
        rdy = acc[i] + PER + 1;
      end
      len = acc[n-1] + PER + TCH + 2;
      for (int k = 0; k < len; k++) begin
        w = -1;
        for (int i = 0; i < n; i++) if (k > acc[i]) w = i;
        if (w < 0) begin
          expv[k] = mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, model_data, 1'b1, 1'b0, 1'b0);
        end else begin
          o = k - acc[w];
          if (o <= PER)
            expv[k] = mk(act, !isa[w], isa[w], !(o > TS && o <= TS + TWP), 1'b0, byt[w],
                         1'b0, 1'b1, 1'b0);
          else if (w < n - 1)
            expv[k] = mk(act, 1'b0, 1'b0, 1'b1, 1'b1, byt[w], 1'b1, 1'b1, 1'b0);
          else if (o <= PER + TCH)
            expv[k] = mk(act, 1'b0, 1'b0, 1'b1, 1'b1, byt[w], 1'b0, 1'b1, 1'b0);
          else
            expv[k] = mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, byt[w], 1'b1, 1'b0, 1'b1);
        end
      end
      for (int k = 0; k < len; k++) begin
        v = -1;
        for (int i = 0; i < n; i++) if (pres[i] <= k && k <= acc[i]) v = i;
        if (v >= 0) begin
          bus.req_valid = 1'b1; bus.req_byte = byt[v]; bus.req_is_addr = isa[v];
          bus.req_last = (v == n - 1); bus.req_ce = cei[v];
        end else begin
          bus.req_valid = 1'b0; bus.req_byte = 8'($urandom); bus.req_is_addr = 1'($urandom);
          bus.req_last = 1'($urandom); bus.req_ce = 3'($urandom);
        end
        @(negedge clk);
        checks++;
        if (obs !== expv[k]) begin
          errors++;
          $display("FAIL random burst %0d cyc %0d got %h want %h", b, k, obs, expv[k]);
        end
        step();
      end
      idle_inputs();
      model_data = byt[n-1];
    end
  endtask

`ifdef NAND_SEQ_STATS_EN
  task automatic test_stats();
    apply_reset();
    test_burst();
    step();
    test_burst();
    step();
    @(negedge clk);
    checks++;
    if (sbytes !== 16'd12 || sbursts !== 16'd2) begin
      errors++;
      $display("FAIL stats got bytes %0d bursts %0d want 12 2", sbytes, sbursts);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_cmd();
    test_burst();
    step();
    test_stall();
    test_reset_mid();
    test_random(40);
`ifdef NAND_SEQ_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
